serial_word_framer: RTL and testbench

//  Upstream feeder for the divisible-by-5 serial detector.
//  - Accepts a parallel WIDTH-bit word over a valid/ready handshake.
//  - Clears the detector, then shifts the word out MSB-first, one bit per clock.
//  - Samples the detector's z output after the last bit and returns the word with a divisible flag.

---
 rtl/serial_word_framer_pkg.sv | 23 ++
 rtl/serial_word_framer_if.sv | 29 ++
 rtl/serial_word_framer.sv | 105 ++++++++++
 tb/tb_serial_word_framer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_framer_pkg.sv
// Shared constants for the serial word framer: state encodings, divisor and a
// constant-evaluable ceil(log2) helper.
package framer_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLR   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    localparam int DIV_BY = 5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_word_framer_if.sv
// Bundle of the framer's upstream handshake, detector-side serial link and
// result outputs. The framer uses the slave view, its environment the master view.
interface serial_word_framer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             det_clr;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_last;
    logic             det_z;
    logic             res_valid;
    logic [WIDTH-1:0] res_word;
    logic             res_div;

    modport slave (
        input  in_valid, in_data, det_z,
        output in_ready, det_clr, ser_bit, ser_valid, ser_last,
               res_valid, res_word, res_div
    );

    modport master (
        output in_valid, in_data, det_z,
        input  in_ready, det_clr, ser_bit, ser_valid, ser_last,
               res_valid, res_word, res_div
    );
endinterface

// File: rtl/serial_word_framer.sv
// Feeds a parallel word MSB-first into an external divisible-by-5 detector and
// reports the word together with the detector's verdict after the last bit.
module serial_word_framer
    import framer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_word_framer_if.slave bus
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] res_word_q, res_word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_div_q, res_div_d;

    logic st_idle, st_clr, st_shift, st_check;
    logic in_ready;
    logic accept;

    always_comb begin
        st_idle  = 1'b0;
        st_clr   = 1'b0;
        st_shift = 1'b0;
        st_check = 1'b0;
        case (state_q)
            S_CLR:   st_clr   = 1'b1;
            S_SHIFT: st_shift = 1'b1;
            S_CHECK: st_check = 1'b1;
            default: st_idle  = 1'b1;
        endcase
    end

    // Ready comes only from state, never from in_valid; held low while in reset.
    assign in_ready = (st_idle | st_check) & ~rst;
    assign accept   = in_ready & bus.in_valid;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        res_word_d = res_word_q;
        cnt_d      = cnt_q;
        res_div_d  = res_div_q;

        if (st_shift) begin
            shreg_d = shreg_q << 1;
            if (cnt_q == '0) begin
                state_d = S_CHECK;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (st_clr) begin
            state_d = S_SHIFT;
        end

        if (st_check) begin
            res_div_d = bus.det_z;
        end

        if (st_idle || st_check) begin
            if (accept) begin
                shreg_d    = bus.in_data;
                res_word_d = bus.in_data;
                cnt_d      = CNT_LOAD;
                state_d    = S_CLR;
            end else begin
                state_d    = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            res_word_q <= '0;
            cnt_q      <= '0;
            res_div_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            res_word_q <= res_word_d;
            cnt_q      <= cnt_d;
            res_div_q  <= res_div_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.det_clr   = st_clr;
    assign bus.ser_valid = st_shift;
    assign bus.ser_bit   = st_shift & shreg_q[WIDTH-1];
    assign bus.ser_last  = st_shift & (cnt_q == '0);
    assign bus.res_valid = st_check;
    assign bus.res_word  = res_word_q;
    // The verdict is live during CHECK and then held until the next CHECK.
    assign bus.res_div   = st_check ? bus.det_z : res_div_q;

endmodule

// File: tb/tb_serial_word_framer.sv
// Bench for serial_word_framer with a behavioural divisible-by-5 detector on the
// serial link and a reference model based on integer modulo.
module tb_serial_word_framer;
    import framer_pkg::*;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 10;
    localparam int LAT    = WIDTH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(PERIOD / 2) clk = ~clk;

    serial_word_framer_if #(.WIDTH(WIDTH)) bus ();

    serial_word_framer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Detector: running residue of the bit stream mod 5, cleared by rst | det_clr.
    logic [2:0] det_res_q;
    always @(posedge clk) begin
        if (rst || bus.det_clr) det_res_q <= 3'd0;
        else det_res_q <= 3'((int'(det_res_q) * 2 + int'(bus.ser_bit)) % 5);
    end
    assign bus.det_z = (det_res_q == 3'd0);

    int  acc_cnt = 0;
    int  res_cnt = 0;
    time acc_time = 0;
    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_time <= $time;
        end
        if (!rst && bus.res_valid) res_cnt <= res_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers w, waits for acceptance, then observes the frame up to its result.
    task automatic run_frame(input logic [7:0] w, input bit keep_valid,
                             output logic [7:0] bits, output int nbits, output int clr_at,
                             output int last_pos, output logic [7:0] rword, output logic rdiv,
                             output int lat, output int idle_err);
        int guard;
        bits = '0; nbits = 0; clr_at = -1; last_pos = -1;
        rword = '0; rdiv = 1'b0; lat = -1; idle_err = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        if (!keep_valid) bus.in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.det_clr && clr_at < 0) clr_at = c;
            if (bus.ser_valid) begin
                bits = {bits[6:0], bus.ser_bit};
                nbits++;
                if (bus.ser_last) last_pos = nbits;
            end else if (bus.ser_bit || bus.ser_last) begin
                idle_err++;
            end
            if (bus.res_valid) begin
                rword = bus.res_word;
                rdiv  = bus.res_div;
                lat   = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h0A;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({bus.det_clr, bus.ser_valid, bus.ser_bit, bus.ser_last, bus.res_valid, bus.res_div} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {bus.det_clr, bus.ser_valid, bus.ser_bit, bus.ser_last, bus.res_valid, bus.res_div});
        end
        checks++;
        if (bus.res_word !== 8'h00) begin
            failures++;
            $display("FAIL reset_res_word got=%h want=00", bus.res_word);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        step();
        checks++;
        if (bus.det_clr !== 1'b0 || acc_cnt !== 0) begin
            failures++;
            $display("FAIL reset_no_handshake det_clr=%b acc=%0d want 0/0", bus.det_clr, acc_cnt);
        end
    endtask

    task automatic test_patterns();
        logic [7:0] words [4] = '{8'h0A, 8'h07, 8'h00, 8'hFF};
        logic       divs  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] bits, rword;
        logic       rdiv;
        int nbits, clr_at, last_pos, lat, idle_err;
        for (int i = 0; i < 4; i++) begin
            run_frame(words[i], 1'b0, bits, nbits, clr_at, last_pos, rword, rdiv, lat, idle_err);
            checks++;
            if (clr_at !== 1) begin
                failures++;
                $display("FAIL pat_det_clr word=%h got_cycle=%0d want=1", words[i], clr_at);
            end
            checks++;
            if (bits !== words[i] || nbits !== WIDTH || last_pos !== WIDTH || idle_err !== 0) begin
                failures++;
                $display("FAIL pat_serial word=%h bits=%h n=%0d last=%0d idle_err=%0d want bits=%h n=8 last=8 idle_err=0",
                         words[i], bits, nbits, last_pos, idle_err, words[i]);
            end
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL pat_latency word=%h got=%0d want=%0d", words[i], lat, LAT);
            end
            checks++;
            if (rword !== words[i] || rdiv !== divs[i]) begin
                failures++;
                $display("FAIL pat_result word=%h got word=%h div=%b want div=%b", words[i], rword, rdiv, divs[i]);
            end
        end
        step();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_word !== 8'hFF || bus.res_div !== 1'b1) begin
            failures++;
            $display("FAIL pat_hold got valid=%b word=%h div=%b want 0/FF/1", bus.res_valid, bus.res_word, bus.res_div);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits, rword;
        logic       rdiv;
        int nbits, clr_at, last_pos, lat, idle_err;
        time t1;
        run_frame(8'h19, 1'b1, bits, nbits, clr_at, last_pos, rword, rdiv, lat, idle_err);
        t1 = acc_time;
        checks++;
        if (rword !== 8'h19 || rdiv !== 1'b1 || lat !== LAT) begin
            failures++;
            $display("FAIL b2b_first got word=%h div=%b lat=%0d want 19/1/%0d", rword, rdiv, lat, LAT);
        end
        run_frame(8'h1A, 1'b0, bits, nbits, clr_at, last_pos, rword, rdiv, lat, idle_err);
        checks++;
        if (acc_time - t1 !== time'(LAT * PERIOD)) begin
            failures++;
            $display("FAIL b2b_spacing got=%0t want=%0d", acc_time - t1, LAT * PERIOD);
        end
        checks++;
        if (clr_at !== 1 || rword !== 8'h1A || rdiv !== 1'b0 || bits !== 8'h1A) begin
            failures++;
            $display("FAIL b2b_second got clr_at=%0d word=%h div=%b bits=%h want 1/1A/0/1A", clr_at, rword, rdiv, bits);
        end
    endtask

    task automatic test_shift_noise();
        logic [7:0] bits;
        int ready_err, a0, found;
        bus.in_valid = 1'b0;
        step();
        bus.in_data  = 8'h0F;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        a0 = acc_cnt;
        bits = '0; ready_err = 0; found = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.ser_valid) begin
                bits = {bits[6:0], bus.ser_bit};
                if (bus.in_ready) ready_err++;
            end
            if (bus.res_valid) begin
                found = 1;
                break;
            end
            bus.in_valid = 1'($urandom % 2);
            bus.in_data  = 8'($urandom);
            step();
        end
        checks++;
        if (ready_err !== 0 || acc_cnt !== a0) begin
            failures++;
            $display("FAIL noise_ready ready_err=%0d accepts=%0d want 0/0", ready_err, acc_cnt - a0);
        end
        checks++;
        if (found !== 1 || bits !== 8'h0F || bus.res_word !== 8'h0F || bus.res_div !== 1'b1) begin
            failures++;
            $display("FAIL noise_frame found=%0d bits=%h word=%h div=%b want 1/0F/0F/1",
                     found, bits, bus.res_word, bus.res_div);
        end
        bus.in_data  = 8'h32;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.det_clr !== 1'b1) begin
            failures++;
            $display("FAIL noise_accept_in_check det_clr=%b want=1", bus.det_clr);
        end
        found = 0;
        for (int c = 1; c <= 20 && !found; c++) begin
            step();
            if (bus.res_valid) found = 1;
        end
        checks++;
        if (found !== 1 || bus.res_word !== 8'h32 || bus.res_div !== 1'b1) begin
            failures++;
            $display("FAIL noise_next found=%0d word=%h div=%b want 1/32/1", found, bus.res_word, bus.res_div);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bits, rword;
        logic       rdiv;
        int nbits, clr_at, last_pos, lat, idle_err, r0;
        bus.in_valid = 1'b0;
        step();
        bus.in_data  = 8'hAB;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (bus.ser_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_shift ser_valid=%b want=1", bus.ser_valid);
        end
        rst = 1'b1;
        r0 = res_cnt;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 ||
            {bus.det_clr, bus.ser_valid, bus.ser_bit, bus.ser_last, bus.res_valid, bus.res_div} !== 6'b0 ||
            bus.res_word !== 8'h00) begin
            failures++;
            $display("FAIL midrst_state ready=%b outs=%b word=%h want 1/000000/00", bus.in_ready,
                     {bus.det_clr, bus.ser_valid, bus.ser_bit, bus.ser_last, bus.res_valid, bus.res_div},
                     bus.res_word);
        end
        repeat (15) step();
        checks++;
        if (res_cnt !== r0) begin
            failures++;
            $display("FAIL midrst_no_result got=%0d want=0", res_cnt - r0);
        end
        run_frame(8'h05, 1'b0, bits, nbits, clr_at, last_pos, rword, rdiv, lat, idle_err);
        checks++;
        if (rword !== 8'h05 || rdiv !== 1'b1 || lat !== LAT) begin
            failures++;
            $display("FAIL midrst_after got word=%h div=%b lat=%0d want 05/1/%0d", rword, rdiv, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [7:0] w, bits, rword;
        logic       rdiv, exp_div;
        int nbits, clr_at, last_pos, lat, idle_err, a0, r0;
        bus.in_valid = 1'b0;
        step();
        a0 = acc_cnt;
        r0 = res_cnt;
        for (int n = 0; n < 1000; n++) begin
            bus.in_valid = 1'b0;
            repeat ($urandom % 3) step();
            w = 8'($urandom);
            exp_div = ((int'(w) % DIV_BY) == 0);
            run_frame(w, 1'b0, bits, nbits, clr_at, last_pos, rword, rdiv, lat, idle_err);
            checks++;
            if (rword !== w || rdiv !== exp_div || bits !== w || lat !== LAT || last_pos !== WIDTH) begin
                failures++;
                $display("FAIL rand_word n=%0d w=%h got word=%h div=%b bits=%h lat=%0d last=%0d want div=%b",
                         n, w, rword, rdiv, bits, lat, last_pos, exp_div);
            end
        end
        step();
        checks++;
        if (acc_cnt - a0 !== 1000 || res_cnt - r0 !== 1000) begin
            failures++;
            $display("FAIL rand_counts accepts=%0d results=%0d want 1000/1000", acc_cnt - a0, res_cnt - r0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_patterns();
        test_back_to_back();
        test_shift_noise();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
